// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the scanner decode:
// key codes, emulator states and the code -> {row, col} mapping.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_STAR = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE
    } emu_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Physical position of each key; bit index of filas/columnas = row/col number.
    function automatic key_pos_t code_to_pos(input logic [3:0] code);
        key_pos_t pos;
        case (code)
            KEY_1:    pos = '{row: 2'd0, col: 2'd0};
            KEY_2:    pos = '{row: 2'd0, col: 2'd1};
            KEY_3:    pos = '{row: 2'd0, col: 2'd2};
            KEY_A:    pos = '{row: 2'd0, col: 2'd3};
            KEY_4:    pos = '{row: 2'd1, col: 2'd0};
            KEY_5:    pos = '{row: 2'd1, col: 2'd1};
            KEY_6:    pos = '{row: 2'd1, col: 2'd2};
            KEY_B:    pos = '{row: 2'd1, col: 2'd3};
            KEY_7:    pos = '{row: 2'd2, col: 2'd0};
            KEY_8:    pos = '{row: 2'd2, col: 2'd1};
            KEY_9:    pos = '{row: 2'd2, col: 2'd2};
            KEY_C:    pos = '{row: 2'd2, col: 2'd3};
            KEY_STAR: pos = '{row: 2'd3, col: 2'd0};
            KEY_0:    pos = '{row: 2'd3, col: 2'd1};
            KEY_HASH: pos = '{row: 2'd3, col: 2'd2};
            default:  pos = '{row: 2'd3, col: 2'd3};  // KEY_D
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/keypad_code_map.sv
// Combinational translation of a 4-bit key code into its row and column.
module keypad_code_map
    import keypad_pkg::*;
(
    input  logic [3:0] code,
    output logic [1:0] row,
    output logic [1:0] col
);

    key_pos_t pos;

    // Look the code up in the shared keypad layout.
    always_comb begin
        pos = code_to_pos(code);
        row = pos.row;
        col = pos.col;
    end

endmodule

// File: rtl/teclado_emulador.sv
// 4x4 matrix-keypad emulator: accepts a key request, closes the matching
// row/column "switch" for HOLD_CYCLES, then opens it for GAP_CYCLES.
module teclado_emulador
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 1_080_000,
    parameter int GAP_CYCLES  = 1_080_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    input  logic       abort,
    output logic       done,
    output logic       aborted
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    emu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic [1:0]       map_row;
    logic [1:0]       map_col;

    keypad_code_map u_code_map (
        .code (key_code),
        .row  (map_row),
        .col  (map_col)
    );

    // Next-state logic: the counter is reloaded on every state entry and only counts down.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    row_d     = map_row;
                    col_d     = map_col;
                    aborted_d = 1'b0;
                    cnt_d     = HOLD_LOAD;
                    state_d   = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q == '0 || abort) begin
                    cnt_d   = GAP_LOAD;
                    state_d = RELEASE;
                    if (abort) begin
                        aborted_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous reset that discards any press in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Behave like a closed switch: the column follows the latched row strobe with no register.
    always_comb begin
        columnas = 4'b0000;
        if (state_q == PRESS && filas[row_q]) begin
            columnas = 4'b0001 << col_q;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = !key_ready;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_teclado_emulador.sv
// Directed bench for teclado_emulador with short hold/gap times.
module tb_teclado_emulador;

    localparam int HOLD = 20;
    localparam int GAP  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       abort;
    logic       done;
    logic       aborted;

    int tests_run    = 0;
    int tests_failed = 0;

    teclado_emulador #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .filas     (filas),
        .columnas  (columnas),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .abort     (abort),
        .done      (done),
        .aborted   (aborted)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    // Present a request for one rising edge; returns at the falling edge of the first PRESS cycle.
    task automatic accept_key(input logic [3:0] code);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Wait (bounded) until the emulator is idle again, noting whether done was seen.
    task automatic wait_idle(input string name, output logic saw_done);
        int n;
        saw_done = 1'b0;
        n = 0;
        while (key_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            n++;
        end
        tests_run++;
        if (key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_timeout: key_ready=%b after %0d cycles, required 1", name, key_ready, n);
        end
    endtask

    task automatic test_reset();
        logic saw_done;
        rst_n = 1'b0; filas = 4'b0000; key_code = 4'd0; key_valid = 1'b0; abort = 1'b0;
        #12;
        tests_run++;
        if (columnas !== 4'b0000 || key_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: col=%b rdy=%b busy=%b done=%b abt=%b, required 0000 1 0 0 0",
                     columnas, key_ready, busy, done, aborted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Reset in the middle of a press.
        filas = 4'b0010;
        accept_key(4'd5);
        repeat (3) @(negedge clk);
        tests_run++;
        if (columnas !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL reset_pre_press: columnas=%b, required 0010", columnas);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (columnas !== 4'b0000 || key_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_press: col=%b rdy=%b busy=%b, required 0000 1 0", columnas, key_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || columnas !== 4'b0000) saw_done = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (saw_done !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_discard: activity_after_reset=%b rdy=%b, required 0 1", saw_done, key_ready);
        end
    endtask

    task automatic test_nominal();
        filas = 4'b0010;
        accept_key(4'd5);
        for (int i = 0; i < HOLD; i++) begin
            tests_run++;
            if (columnas !== 4'b0010 || busy !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL nominal_press[%0d]: col=%b busy=%b done=%b, required 0010 1 0", i, columnas, busy, done);
            end
            @(negedge clk);
        end
        for (int i = 0; i < GAP; i++) begin
            tests_run++;
            if (columnas !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL nominal_release[%0d]: col=%b busy=%b done=%b, required 0000 1 0", i, columnas, busy, done);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || key_ready !== 1'b1 || aborted !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL nominal_done: done=%b rdy=%b abt=%b, required 1 1 0", done, key_ready, aborted);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL nominal_done_width: done=%b rdy=%b, required 0 1", done, key_ready);
        end
    endtask

    task automatic test_row_gating();
        logic [3:0] exp_col;
        filas = 4'b0001;
        accept_key(4'd13);
        for (int i = 0; i < HOLD; i++) begin
            filas = 4'(1 << ((i / 4) % 4));
            #1;
            exp_col = filas[3] ? 4'b1000 : 4'b0000;
            tests_run++;
            if (columnas !== exp_col) begin
                tests_failed++;
                $display("[TB] FAIL gating[%0d]: filas=%b col=%b, required %b", i, filas, columnas, exp_col);
            end
            if (i == 13) begin
                filas = 4'b0100;
                #1;
                tests_run++;
                if (columnas !== 4'b0000) begin
                    tests_failed++;
                    $display("[TB] FAIL gating_comb_off: col=%b, required 0000", columnas);
                end
                filas = 4'b1000;
                #1;
                tests_run++;
                if (columnas !== 4'b1000) begin
                    tests_failed++;
                    $display("[TB] FAIL gating_comb_on: col=%b, required 1000", columnas);
                end
            end
            @(negedge clk);
        end
        filas = 4'b1000;
        for (int i = 0; i < GAP; i++) begin
            tests_run++;
            if (columnas !== 4'b0000 || busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL gating_release[%0d]: col=%b busy=%b, required 0000 1", i, columnas, busy);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL gating_done: done=%b rdy=%b, required 1 1", done, key_ready);
        end
    endtask

    task automatic test_busy_ignore();
        logic saw_done;
        int   dones;
        filas = 4'b0101;
        accept_key(4'd7);
        key_code  = 4'd2;
        key_valid = 1'b1;
        dones = 0;
        for (int i = 0; i < HOLD + GAP; i++) begin
            if (done === 1'b1) dones++;
            tests_run++;
            if (columnas !== ((i < HOLD) ? 4'b0001 : 4'b0000) || key_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL busy_ignore[%0d]: col=%b rdy=%b, required %b 0",
                         i, columnas, key_ready, (i < HOLD) ? 4'b0001 : 4'b0000);
            end
            @(negedge clk);
        end
        if (done === 1'b1) dones++;
        tests_run++;
        if (dones != 1 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_ignore_done: dones=%0d rdy=%b, required 1 1", dones, key_ready);
        end
        @(negedge clk);
        key_valid = 1'b0;
        tests_run++;
        if (columnas !== 4'b0010 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_ignore_second: col=%b busy=%b, required 0010 1", columnas, busy);
        end
        wait_idle("busy_ignore", saw_done);
        tests_run++;
        if (saw_done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_ignore_second_done: seen=%b, required 1", saw_done);
        end
    endtask

    task automatic test_abort();
        logic saw_done;
        filas = 4'b1000;
        accept_key(4'd15);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (columnas !== 4'b0001) begin
                tests_failed++;
                $display("[TB] FAIL abort_press[%0d]: col=%b, required 0001", i, columnas);
            end
            @(negedge clk);
        end
        abort = 1'b1;
        #1;
        tests_run++;
        if (columnas !== 4'b0001 || aborted !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_same_cycle: col=%b abt=%b, required 0001 0", columnas, aborted);
        end
        @(negedge clk);
        for (int i = 0; i < GAP; i++) begin
            tests_run++;
            if (columnas !== 4'b0000 || busy !== 1'b1 || aborted !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL abort_release[%0d]: col=%b busy=%b abt=%b done=%b, required 0000 1 1 0",
                         i, columnas, busy, aborted, done);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || key_ready !== 1'b1 || aborted !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_done: done=%b rdy=%b abt=%b, required 1 1 1", done, key_ready, aborted);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (aborted !== 1'b1 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle_hold: abt=%b rdy=%b, required 1 1", aborted, key_ready);
        end
        abort = 1'b0;
        filas = 4'b0001;
        accept_key(4'd1);
        tests_run++;
        if (aborted !== 1'b0 || columnas !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL abort_clear: abt=%b col=%b, required 0 0001", aborted, columnas);
        end
        wait_idle("abort", saw_done);
        tests_run++;
        if (saw_done !== 1'b1 || aborted !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_followup: done_seen=%b abt=%b, required 1 0", saw_done, aborted);
        end
    endtask

    // Run the scenarios in order and report.
    initial begin
        test_reset();
        test_nominal();
        test_row_gating();
        test_busy_ignore();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
